// File: rtl/motor_pwm_drive.sv
// H-bridge PWM driver: period-synchronous duty/dir/brake updates with registered, glitch-free bridge outputs.
// Optional MOTOR_PWM_DEADTIME_EN compiles in the DEAD state that guards every direction/brake transition.
module motor_pwm_drive #(
  parameter int unsigned DEADTIME = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pwm,
  input  logic        dir,
  input  logic        brake,
  input  logic [7:0]  prescale,
  output logic        in_a,
  output logic        in_b,
  output logic        period_start
);

  localparam logic [12:0] CNT_LAST = 13'd8190;

  generate
    if (DEADTIME < 1 || DEADTIME > 255) begin : g_bad_deadtime
      $error("motor_pwm_drive: DEADTIME must be within 1..255");
    end
  endgenerate

`ifdef MOTOR_PWM_DEADTIME_EN
  localparam logic [7:0] DT_LAST = 8'(DEADTIME - 1);
  typedef enum logic [1:0] {RUN, DEAD, BRAKE} state_t;
`else
  typedef enum logic [0:0] {RUN, BRAKE} state_t;
`endif

  logic [7:0]  pre_cnt;
  logic        tick;
  logic [12:0] cnt;
  logic        wrap;
  logic [12:0] duty_s;
  logic        dir_s;
  logic        brake_s;
  state_t      state;
  state_t      state_nxt;
  logic        act;
  logic        a_p0;
  logic        b_p0;

`ifdef MOTOR_PWM_DEADTIME_EN
  state_t      tgt;
  state_t      tgt_nxt;
  state_t      tgt_new;
  logic [7:0]  dt_cnt;
  logic [7:0]  dt_nxt;
  logic        dir_flip;
`endif

  // ---- stage p0: prescaler, period counter, shadow registers ----
  assign tick = (pre_cnt == prescale);
  assign wrap = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 8'd0;
      cnt     <= 13'd0;
    end else begin
      pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (tick) begin
        cnt <= (cnt == CNT_LAST) ? 13'd0 : cnt + 13'd1;
      end
    end
  end

  // Shadows change only at the period boundary so a period is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_s  <= 13'd0;
      dir_s   <= 1'b0;
      brake_s <= 1'b0;
    end else if (wrap) begin
      duty_s  <= pwm;
      dir_s   <= dir;
      brake_s <= brake;
    end
  end

  // ---- bridge state machine ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
`ifdef MOTOR_PWM_DEADTIME_EN
      tgt    <= RUN;
      dt_cnt <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
`ifdef MOTOR_PWM_DEADTIME_EN
      tgt    <= tgt_nxt;
      dt_cnt <= dt_nxt;
`endif
    end
  end

`ifdef MOTOR_PWM_DEADTIME_EN
  // At wrap the inputs are exactly what the shadows are about to load.
  assign tgt_new  = brake ? BRAKE : RUN;
  assign dir_flip = (dir != dir_s) && (pwm != 13'd0);

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    dt_nxt    = dt_cnt;
    case (state)
      RUN: begin
        if (wrap && (brake || dir_flip)) begin
          state_nxt = DEAD;
          tgt_nxt   = tgt_new;
          dt_nxt    = 8'd0;
        end
      end
      BRAKE: begin
        if (wrap && !brake) begin
          state_nxt = DEAD;
          tgt_nxt   = RUN;
          dt_nxt    = 8'd0;
        end
      end
      DEAD: begin
        // A wrap while dead re-targets without restarting the dead interval.
        if (wrap) begin
          tgt_nxt = tgt_new;
        end
        if (dt_cnt == DT_LAST) begin
          state_nxt = wrap ? tgt_new : tgt;
        end else begin
          dt_nxt = dt_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        tgt_nxt   = RUN;
        dt_nxt    = 8'd0;
      end
    endcase
  end
`else
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (wrap && brake)  state_nxt = BRAKE;
      BRAKE:   if (wrap && !brake) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end
`endif

  // ---- stage p1: registered bridge drive ----
  assign act = (cnt < duty_s);

  always_comb begin
    a_p0 = 1'b0;
    b_p0 = 1'b0;
    case (state)
      RUN: begin
        a_p0 = act & dir_s;
        b_p0 = act & ~dir_s;
      end
      BRAKE: begin
        a_p0 = 1'b1;
        b_p0 = 1'b1;
      end
      default: begin
        a_p0 = 1'b0;
        b_p0 = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_a         <= 1'b0;
      in_b         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      in_a         <= a_p0;
      in_b         <= b_p0;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Directed bench for motor_pwm_drive: per-cycle behavioural model compare plus per-period literal counts.
module tb_motor_pwm_drive;

`ifdef MOTOR_PWM_DEADTIME_EN
  localparam int DT = 4;
`else
  localparam int DT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] pwm;
  logic        dir;
  logic        brake;
  logic [7:0]  prescale;
  logic        in_a;
  logic        in_b;
  logic        period_start;

  motor_pwm_drive #(.DEADTIME(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm          (pwm),
    .dir          (dir),
    .brake        (brake),
    .prescale     (prescale),
    .in_a         (in_a),
    .in_b         (in_b),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state: tick position in period, dead clocks left, braking mode
  int m_pre = 0;
  int m_pos = 0;
  int m_duty = 0;
  bit m_dir = 0;
  bit m_brk_mode = 0;
  int m_dead = 0;
  bit ea = 0, eb = 0, eps = 0;
  bit m_tick, m_wrap, m_was_dead, m_act, m_flip;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pre = 0; m_pos = 0; m_duty = 0; m_dir = 0; m_brk_mode = 0; m_dead = 0;
        ea = 0; eb = 0; eps = 0;
      end else begin
        if (m_dead > 0) begin
          ea = 0; eb = 0;
        end else if (m_brk_mode) begin
          ea = 1; eb = 1;
        end else begin
          m_act = (m_pos < m_duty);
          ea = m_act && m_dir;
          eb = m_act && !m_dir;
        end
        m_tick = (m_pre == int'(prescale));
        m_wrap = m_tick && (m_pos == 8190);
        eps = m_wrap;
        m_pre = m_tick ? 0 : (m_pre + 1) % 256;
        if (m_tick) m_pos = m_wrap ? 0 : m_pos + 1;
        m_was_dead = (m_dead > 0);
        if (m_was_dead) m_dead = m_dead - 1;
        if (m_wrap) begin
          m_flip = (dir != m_dir) && (pwm != 0);
          if (m_was_dead) m_brk_mode = brake;
          else if (!m_brk_mode && brake) begin m_brk_mode = 1; m_dead = DT; end
          else if (m_brk_mode && !brake) begin m_brk_mode = 0; m_dead = DT; end
          else if (!m_brk_mode && m_flip) m_dead = DT;
          m_duty = int'(pwm);
          m_dir = dir;
        end
      end
    end
  end

  // per-period tallies, closed on each period_start pulse
  int cur_a = 0, cur_b = 0, cur_ab = 0, cur_len = 0;
  int rec_a[$], rec_b[$], rec_ab[$], rec_len[$];

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_a = 0; cur_b = 0; cur_ab = 0; cur_len = 0;
      end else begin
        checks++;
        if ({in_a, in_b, period_start} !== {ea, eb, eps}) begin
          errors++;
          $display("FAIL cycle t=%0t: got a=%b b=%b ps=%b, expected a=%b b=%b ps=%b",
                   $time, in_a, in_b, period_start, ea, eb, eps);
        end
        cur_a += int'(in_a);
        cur_b += int'(in_b);
        cur_ab += int'(in_a & in_b);
        cur_len++;
        if (period_start === 1'b1) begin
          rec_a.push_back(cur_a); rec_b.push_back(cur_b);
          rec_ab.push_back(cur_ab); rec_len.push_back(cur_len);
          cur_a = 0; cur_b = 0; cur_ab = 0; cur_len = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_rec(input int n, input int bound);
    for (int i = 0; i < bound && rec_len.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    if (rec_len.size() < n) begin
      errors++;
      $display("FAIL period_wait: got %0d periods, expected %0d", rec_len.size(), n);
      finish_sim();
    end
  endtask

  initial begin : stim
    rst_n = 1'b0; pwm = 13'd4096; dir = 1'b1; brake = 1'b0; prescale = 8'd0;
    wait_clks(3);
    chk("reset_in_a", int'(in_a), 0);
    chk("reset_in_b", int'(in_b), 0);
    chk("reset_ps", int'(period_start), 0);
    rst_n = 1'b1;

    // R0: nothing loaded yet, first wrap after 8191 clks
    wait_rec(1, 9000);
    chk("r0_len", rec_len[0], 8191);
    chk("r0_a", rec_a[0], 0);
    chk("r0_b", rec_b[0], 0);

    // P1: pwm 4096 dir 1 (first load flips dir from its reset value)
    wait_clks(4000);
    pwm = 13'd0;
    wait_rec(2, 9000);
    chk("p1_len", rec_len[1], 8191);
    chk("p1_a", rec_a[1], 4096 - DT);
    chk("p1_b", rec_b[1], 0);

    // P2: pwm 0
    wait_clks(4000);
    pwm = 13'd8191;
    wait_rec(3, 9000);
    chk("p2_a", rec_a[2], 0);
    chk("p2_b", rec_b[2], 0);

    // P3: pwm 8191, then asynchronous reset mid-period
    wait_clks(4000);
    chk("p3_full_on", int'(in_a), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_a", int'(in_a), 0);
    chk("async_rst_b", int'(in_b), 0);
    chk("async_rst_ps", int'(period_start), 0);
    pwm = 13'd100; dir = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;

    wait_rec(4, 9000);
    chk("r1_len", rec_len[3], 8191);
    chk("r1_a", rec_a[3], 0);
    chk("r1_b", rec_b[3], 0);

    // P4: pwm 100 dir 1; reverse direction mid-period
    wait_clks(4000);
    dir = 1'b0;
    wait_rec(5, 9000);
    chk("p4_a", rec_a[4], 100 - DT);
    chk("p4_b", rec_b[4], 0);

    // P5: reversed drive; request brake mid-period
    wait_clks(4000);
    brake = 1'b1;
    wait_rec(6, 9000);
    chk("p5_a", rec_a[5], 0);
    chk("p5_b", rec_b[5], 100 - DT);

    // P6: braking; release brake, then switch to prescale 1 after 8091 ticks
    wait_clks(4000);
    brake = 1'b0; pwm = 13'd10; dir = 1'b0;
    wait_clks(4091);
    prescale = 8'd1;
    wait_rec(7, 9000);
    chk("p6_len", rec_len[6], 8091 + 2 * 100);
    chk("p6_brake", rec_ab[6], 8291 - DT);

    // P7: prescale 1 after brake release
    wait_rec(8, 17000);
    chk("p7_len", rec_len[7], 16382);
    chk("p7_a", rec_a[7], 0);
    chk("p7_b", rec_b[7], 20 - DT);

    // P8: steady prescale 1 drive, in_b only during cnt 0..9
    wait_clks(1000);
    chk("p8_b", cur_b, 20);
    chk("p8_a", cur_a, 0);

    finish_sim();
  end

endmodule
